imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them sequentially into the 32-word instruction memory, and holds the core in reset until the image is fully written. Its `cpu_reset` output drives the core's PC reset; its write port drives the instruction memory's write side.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the 32-word instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// Latency: write strobe 1 cycle after the 4th byte of a word; done/cpu_reset release 1 cycle after the final byte is accepted.
// Backpressure: byte_ready is high in IDLE/LOAD/CHECK and low in DONE/ERROR; byte_valid low simply stalls.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);
    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W:0]   rem, rem_nxt;
    logic [1:0]        bidx, bidx_nxt;
    logic [23:0]       shreg, shreg_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [31:0]       wdata_nxt;
    logic [31:0]       word;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        acc, acc_nxt;
`endif

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            S_IDLE, S_LOAD:  byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:         byte_ready = 1'b1;
`endif
            default:         byte_ready = 1'b0;
        endcase
    end

    assign accept = byte_valid && byte_ready;
    assign word   = {shreg, byte_in};

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        rem_nxt   = rem;
        bidx_nxt  = bidx;
        shreg_nxt = shreg;
        we_nxt    = 1'b0;
        waddr_nxt = imem_addr;
        wdata_nxt = imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_nxt   = acc;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (byte_in > DEPTH_B) begin
                        state_nxt = S_ERROR;
                    end else begin
                        // A zero count means a full memory image.
                        rem_nxt   = (byte_in == 8'd0) ? DEPTH_W : byte_in[ADDR_W:0];
                        addr_nxt  = '0;
                        bidx_nxt  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc_nxt   = 8'd0;
`endif
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    shreg_nxt = word[23:0];
                    bidx_nxt  = bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_nxt   = acc ^ byte_in;
`endif
                    if (bidx == 2'd3) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = addr;
                        wdata_nxt = word;
                        // Address wraps only after the final word, where it is no longer used.
                        addr_nxt  = addr + 1'b1;
                        rem_nxt   = rem - REM_ONE;
                        if (rem == REM_ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_nxt = S_CHECK;
`else
                            state_nxt = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_nxt = (byte_in == acc) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            rem        <= '0;
            bidx       <= 2'd0;
            shreg      <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= 8'd0;
`endif
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            rem        <= rem_nxt;
            bidx       <= bidx_nxt;
            shreg      <= shreg_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= waddr_nxt;
            imem_wdata <= wdata_nxt;
            // Status follows the current state, so release lands one edge after the last write.
            cpu_reset  <= (state != S_DONE);
            done       <= (state == S_DONE);
            err        <= (state == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= acc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of image loads plus hand-written release, gap, reset and terminal-state sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq_addr.push_back(32'(imem_addr));
            wq_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, " byte_ready"}, byte_ready, 1'b1);
        chk1({tag, " imem_we"}, imem_we, 1'b0);
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
        chk1({tag, " cpu_reset"}, cpu_reset, 1'b1);
        chk1({tag, " done"}, done, 1'b0);
        chk1({tag, " err"}, err, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) begin
            byte_in    = 8'($urandom);
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        send_byte(b);
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    function automatic logic [7:0] pat(input int v, input int k);
        return 8'(k * 29 + v * 11 + 3);
    endfunction

    typedef struct {
        logic [7:0] cnt;
        int         nwords;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0]  spec_b[8];
        logic [31:0] gap_w[3];
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0]  x;
`endif

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;

        vecs[0] = '{8'd1,   1,  1'b0};
        vecs[1] = '{8'd2,   2,  1'b0};
        vecs[2] = '{8'd31,  31, 1'b0};
        vecs[3] = '{8'd32,  32, 1'b0};
        vecs[4] = '{8'd0,   32, 1'b0};
        vecs[5] = '{8'd33,  0,  1'b1};
        vecs[6] = '{8'hFF,  0,  1'b1};

        for (int i = 0; i < 7; i++) begin
            do_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = 8'd0;
`endif
            send_byte(vecs[i].cnt);
            for (int k = 0; k < 4 * vecs[i].nwords; k++) begin
                send_byte(pat(i, k));
`ifdef IMEM_LOADER_CHECKSUM_EN
                x = x ^ pat(i, k);
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (!vecs[i].exp_err) send_byte(x);
`endif
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d nwrites", i), wq_addr.size(), vecs[i].nwords);
            for (int w = 0; w < wq_addr.size() && w < vecs[i].nwords; w++) begin
                chk($sformatf("v%0d addr%0d", i, w), wq_addr[w], w);
                chk($sformatf("v%0d data%0d", i, w), wq_data[w],
                    {pat(i, 4*w), pat(i, 4*w+1), pat(i, 4*w+2), pat(i, 4*w+3)});
            end
            chk1($sformatf("v%0d done", i), done, !vecs[i].exp_err);
            chk1($sformatf("v%0d err", i), err, vecs[i].exp_err);
            chk1($sformatf("v%0d cpu_reset", i), cpu_reset, vecs[i].exp_err);
            chk1($sformatf("v%0d byte_ready", i), byte_ready, 1'b0);
        end

        // Two-word image, back to back, with release timing.
        spec_b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
        do_reset();
        send_byte(8'd2);
        for (int k = 0; k < 8; k++) begin
            send_byte(spec_b[k]);
            if (k == 3) begin
                chk1("spec w0 we", imem_we, 1'b1);
                chk("spec w0 addr", 32'(imem_addr), 32'd0);
                chk("spec w0 data", imem_wdata, 32'h20080005);
            end
        end
        chk1("spec w1 we", imem_we, 1'b1);
        chk("spec w1 addr", 32'(imem_addr), 32'd1);
        chk("spec w1 data", imem_wdata, 32'hAC010004);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h84);
`endif
        chk1("spec cpu_reset held", cpu_reset, 1'b1);
        chk1("spec done not yet", done, 1'b0);
        @(posedge clk);
        #1;
        chk1("spec cpu_reset released", cpu_reset, 1'b0);
        chk1("spec done", done, 1'b1);
        chk1("spec imem_we low", imem_we, 1'b0);
        chk("spec nwrites", wq_addr.size(), 2);

        // Terminal state ignores a held byte_valid.
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk("held nwrites", wq_addr.size(), 2);
        chk1("held byte_ready", byte_ready, 1'b0);
        chk1("held done", done, 1'b1);

        // Three-word image with random valid gaps.
        gap_w = '{32'h01234567, 32'h89ABCDEF, 32'hF00DCAFE};
        do_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'd0;
`endif
        send_gap(8'd3);
        for (int w = 0; w < 3; w++) begin
            for (int b = 3; b >= 0; b--) begin
                send_gap(gap_w[w][8*b +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x = x ^ gap_w[w][8*b +: 8];
`endif
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_gap(x);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("gap nwrites", wq_addr.size(), 3);
        for (int w = 0; w < wq_addr.size() && w < 3; w++) begin
            chk($sformatf("gap addr%0d", w), wq_addr[w], w);
            chk($sformatf("gap data%0d", w), wq_data[w], gap_w[w]);
        end
        chk1("gap done", done, 1'b1);

        // Reset in the middle of a load, then a fresh one-word image.
        do_reset();
        send_byte(8'd4);
        for (int k = 0; k < 6; k++) send_byte(8'h11 * 8'(k + 1));
        reset = 1'b1;
        #1;
        check_reset_vals("midrst async");
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst held");
        byte_valid = 1'b0;
        reset      = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        send_byte(8'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("midrst nwrites", wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            chk("midrst addr", wq_addr[0], 32'd0);
            chk("midrst data", wq_data[0], 32'hDEADBEEF);
        end
        chk1("midrst done", done, 1'b1);
        chk1("midrst err", err, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on the same one-word image.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            send_byte(8'd1);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
            send_byte(8'h04);
            send_byte((t == 0) ? 8'h04 : 8'h05);
            chk1($sformatf("ck%0d cpu_reset held", t), cpu_reset, 1'b1);
            @(posedge clk);
            #1;
            chk1($sformatf("ck%0d done", t), done, t == 0);
            chk1($sformatf("ck%0d err", t), err, t == 1);
            chk1($sformatf("ck%0d cpu_reset", t), cpu_reset, t == 1);
            chk($sformatf("ck%0d nwrites", t), wq_addr.size(), 1);
            if (wq_addr.size() > 0) begin
                chk($sformatf("ck%0d addr", t), wq_addr[0], 32'd0);
                chk($sformatf("ck%0d data", t), wq_data[0], 32'h01020304);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
